// File: rtl/mem_arbiter_if.sv
// Bus bundle between mem_arbiter, its two requesters and the shared
// single-port memory.
//
//   Port A / Port B (x = a, b)
//     req_x    level request
//     we_x     1 = write, 0 = read (sampled with req_x)
//     addr_x   access address
//     wdata_x  write data
//     ack_x    one-cycle completion pulse
//     gnt_x    port owns the memory (ACC and DONE)
//     rdata_x  last read data returned to the port
//   lock_b     B wins every arbitration in which it requests
//   Memory
//     mem_en, mem_we, mem_addr, mem_wdata  driven by the arbiter
//     mem_rdata                           valid on the last ACC cycle
//
// slave  : the arbiter's view
// master : the environment's view (requesters + memory)
interface mem_arbiter_if #(
  parameter int word_size = 8
);
  logic                 req_a;
  logic                 we_a;
  logic [word_size-1:0] addr_a;
  logic [word_size-1:0] wdata_a;
  logic                 ack_a;
  logic                 gnt_a;
  logic [word_size-1:0] rdata_a;

  logic                 req_b;
  logic                 we_b;
  logic [word_size-1:0] addr_b;
  logic [word_size-1:0] wdata_b;
  logic                 ack_b;
  logic                 gnt_b;
  logic [word_size-1:0] rdata_b;

  logic                 lock_b;

  logic                 mem_en;
  logic                 mem_we;
  logic [word_size-1:0] mem_addr;
  logic [word_size-1:0] mem_wdata;
  logic [word_size-1:0] mem_rdata;

  modport slave (
    input  req_a, we_a, addr_a, wdata_a,
    input  req_b, we_b, addr_b, wdata_b,
    input  lock_b, mem_rdata,
    output ack_a, gnt_a, rdata_a,
    output ack_b, gnt_b, rdata_b,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_a, we_a, addr_a, wdata_a,
    output req_b, we_b, addr_b, wdata_b,
    output lock_b, mem_rdata,
    input  ack_a, gnt_a, rdata_a,
    input  ack_b, gnt_b, rdata_b,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between port A (processor
// address/bus path) and port B (program loader / debug).
//
// Round-robin arbitration with an optional B lock, a fixed mem_wait-cycle
// memory access and a one-cycle acknowledge per request. All outputs are
// registered and cleared asynchronously by rst (active low), so an access
// in flight is aborted immediately and never acknowledged.
//
// Ports
//   clk  system clock, rising edge
//   rst  asynchronous reset, active low
//   bus  mem_arbiter_if.slave (requester A/B handshakes, lock_b, memory)
//
// Parameters
//   word_size   address/data width
//   mem_wait    cycles mem_en is held per access (1..7)
//   state_size  state register width
module mem_arbiter #(
  parameter int word_size  = 8,
  parameter int mem_wait   = 1,
  parameter int state_size = 2
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus
);

  localparam int unsigned CW = 3;
  localparam logic [CW-1:0] CNT_LOAD = CW'(mem_wait - 1);

  typedef enum logic [state_size-1:0] {
    S_IDLE,
    S_ACC,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 last_b_q, last_b_d;   // 1: B won the last arbitration
  logic                 ack_a_q, ack_a_d;
  logic                 ack_b_q, ack_b_d;
  logic                 gnt_a_q, gnt_a_d;
  logic                 gnt_b_q, gnt_b_d;
  logic                 mem_en_q, mem_en_d;
  logic                 mem_we_q, mem_we_d;
  logic [word_size-1:0] mem_addr_q, mem_addr_d;
  logic [word_size-1:0] mem_wdata_q, mem_wdata_d;
  logic [word_size-1:0] rdata_a_q, rdata_a_d;
  logic [word_size-1:0] rdata_b_q, rdata_b_d;
  logic                 pick_b;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_b_d    = last_b_q;
    ack_a_d     = ack_a_q;
    ack_b_d     = ack_b_q;
    gnt_a_d     = gnt_a_q;
    gnt_b_d     = gnt_b_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_a_d   = rdata_a_q;
    rdata_b_d   = rdata_b_q;
    pick_b      = 1'b0;

    case (state_q)
      S_IDLE: begin
        ack_a_d  = 1'b0;
        ack_b_d  = 1'b0;
        gnt_a_d  = 1'b0;
        gnt_b_d  = 1'b0;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        if (bus.req_a || bus.req_b) begin
          // B wins when alone, when locked, or on a tie after A won last.
          pick_b = bus.req_b && (!bus.req_a || bus.lock_b || !last_b_q);
          if (pick_b) begin
            mem_addr_d  = bus.addr_b;
            mem_wdata_d = bus.wdata_b;
            mem_we_d    = bus.we_b;
            gnt_b_d     = 1'b1;
          end else begin
            mem_addr_d  = bus.addr_a;
            mem_wdata_d = bus.wdata_a;
            mem_we_d    = bus.we_a;
            gnt_a_d     = 1'b1;
          end
          mem_en_d = 1'b1;
          last_b_d = pick_b;
          cnt_d    = CNT_LOAD;
          state_d  = S_ACC;
        end
      end

      S_ACC: begin
        if (cnt_q == '0) begin
          // Last enable cycle: mem_rdata is valid now.
          if (!mem_we_q) begin
            if (gnt_b_q) begin
              rdata_b_d = bus.mem_rdata;
            end else begin
              rdata_a_d = bus.mem_rdata;
            end
          end
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          ack_a_d  = gnt_a_q;
          ack_b_d  = gnt_b_q;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_DONE: begin
        ack_a_d = 1'b0;
        ack_b_d = 1'b0;
        gnt_a_d = 1'b0;
        gnt_b_d = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        // Unused encoding: drop any ownership and recover to idle.
        ack_a_d  = 1'b0;
        ack_b_d  = 1'b0;
        gnt_a_d  = 1'b0;
        gnt_b_d  = 1'b0;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        cnt_d    = '0;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      last_b_q    <= 1'b1;
      ack_a_q     <= 1'b0;
      ack_b_q     <= 1'b0;
      gnt_a_q     <= 1'b0;
      gnt_b_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_a_q   <= '0;
      rdata_b_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_b_q    <= last_b_d;
      ack_a_q     <= ack_a_d;
      ack_b_q     <= ack_b_d;
      gnt_a_q     <= gnt_a_d;
      gnt_b_q     <= gnt_b_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_a_q   <= rdata_a_d;
      rdata_b_q   <= rdata_b_d;
    end
  end

  assign bus.ack_a     = ack_a_q;
  assign bus.ack_b     = ack_b_q;
  assign bus.gnt_a     = gnt_a_q;
  assign bus.gnt_b     = gnt_b_q;
  assign bus.rdata_a   = rdata_a_q;
  assign bus.rdata_b   = rdata_b_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  a_gnt_mutex : assert property (@(posedge clk) disable iff (!rst)
    !(gnt_a_q && gnt_b_q));
  a_ack_mutex : assert property (@(posedge clk) disable iff (!rst)
    !(ack_a_q && ack_b_q));

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic clk;
  logic rst;

  // Index 0: arbiter with mem_wait=1, index 1: arbiter with mem_wait=3.
  logic       req_a_r [2];
  logic       we_a_r  [2];
  logic [7:0] addr_a_r [2];
  logic [7:0] wdata_a_r [2];
  logic       req_b_r [2];
  logic       we_b_r  [2];
  logic [7:0] addr_b_r [2];
  logic [7:0] wdata_b_r [2];
  logic       lock_r  [2];

  logic       ack_a_w [2];
  logic       ack_b_w [2];
  logic       gnt_a_w [2];
  logic       gnt_b_w [2];
  logic       en_w    [2];
  logic       mwe_w   [2];
  logic [7:0] maddr_w [2];
  logic [7:0] mwd_w   [2];
  logic [7:0] rd_a_w  [2];
  logic [7:0] rd_b_w  [2];

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit         port;   // 0 = A, 1 = B
    logic [7:0] rd;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  mem_arbiter_if #(.word_size(8)) bus0 ();
  mem_arbiter_if #(.word_size(8)) bus1 ();

  mem_arbiter #(.word_size(8), .mem_wait(1), .state_size(2)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  mem_arbiter #(.word_size(8), .mem_wait(3), .state_size(2)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  assign bus0.req_a   = req_a_r[0];
  assign bus0.we_a    = we_a_r[0];
  assign bus0.addr_a  = addr_a_r[0];
  assign bus0.wdata_a = wdata_a_r[0];
  assign bus0.req_b   = req_b_r[0];
  assign bus0.we_b    = we_b_r[0];
  assign bus0.addr_b  = addr_b_r[0];
  assign bus0.wdata_b = wdata_b_r[0];
  assign bus0.lock_b  = lock_r[0];
  assign bus0.mem_rdata = mem0[bus0.mem_addr];
  assign ack_a_w[0] = bus0.ack_a;
  assign ack_b_w[0] = bus0.ack_b;
  assign gnt_a_w[0] = bus0.gnt_a;
  assign gnt_b_w[0] = bus0.gnt_b;
  assign en_w[0]    = bus0.mem_en;
  assign mwe_w[0]   = bus0.mem_we;
  assign maddr_w[0] = bus0.mem_addr;
  assign mwd_w[0]   = bus0.mem_wdata;
  assign rd_a_w[0]  = bus0.rdata_a;
  assign rd_b_w[0]  = bus0.rdata_b;

  assign bus1.req_a   = req_a_r[1];
  assign bus1.we_a    = we_a_r[1];
  assign bus1.addr_a  = addr_a_r[1];
  assign bus1.wdata_a = wdata_a_r[1];
  assign bus1.req_b   = req_b_r[1];
  assign bus1.we_b    = we_b_r[1];
  assign bus1.addr_b  = addr_b_r[1];
  assign bus1.wdata_b = wdata_b_r[1];
  assign bus1.lock_b  = lock_r[1];
  assign bus1.mem_rdata = mem1[bus1.mem_addr];
  assign ack_a_w[1] = bus1.ack_a;
  assign ack_b_w[1] = bus1.ack_b;
  assign gnt_a_w[1] = bus1.gnt_a;
  assign gnt_b_w[1] = bus1.gnt_b;
  assign en_w[1]    = bus1.mem_en;
  assign mwe_w[1]   = bus1.mem_we;
  assign maddr_w[1] = bus1.mem_addr;
  assign mwd_w[1]   = bus1.mem_wdata;
  assign rd_a_w[1]  = bus1.rdata_a;
  assign rd_b_w[1]  = bus1.rdata_b;

  // Memory models: combinational read, write on each enabled write cycle.
  always @(posedge clk) begin
    if (bus0.mem_en && bus0.mem_we) mem0[bus0.mem_addr] <= bus0.mem_wdata;
    if (bus1.mem_en && bus1.mem_we) mem1[bus1.mem_addr] <= bus1.mem_wdata;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int k, input bit port, input logic [7:0] rd);
    exp_t e;
    e.port = port;
    e.rd   = rd;
    if (k == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  task automatic drive(input int k, input bit port, input logic req,
                       input logic we, input logic [7:0] a, input logic [7:0] d);
    if (port) begin
      req_b_r[k] = req; we_b_r[k] = we; addr_b_r[k] = a; wdata_b_r[k] = d;
    end else begin
      req_a_r[k] = req; we_a_r[k] = we; addr_a_r[k] = a; wdata_a_r[k] = d;
    end
  endtask

  // Raise a request, wait (bounded) for its ack, drop req on the ack cycle.
  task automatic requester(input int k, input bit port, input int n, input logic we,
                           input logic [7:0] a, input logic [7:0] d, input int unlock_after);
    bit got;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive(k, port, 1'b1, we, a, d);
      got = 1'b0;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        if ((port ? ack_b_w[k] : ack_a_w[k]) === 1'b1) begin
          got = 1'b1;
          break;
        end
      end
      chk($sformatf("ack_wait_k%0d_p%0d_n%0d", k, port, i), got, 1);
      drive(k, port, 1'b0, we, a, d);
      if (unlock_after == i + 1) lock_r[k] = 1'b0;
    end
  endtask

  // Scoreboard monitor: pops one expectation per presented ack.
  task automatic monitor(input int k);
    exp_t e;
    bit   port;
    total++;
    if (gnt_a_w[k] === 1'b1 && gnt_b_w[k] === 1'b1) begin
      bad++;
      $display("FAIL gnt_mutex_k%0d: gnt_a=%b gnt_b=%b expected not both", k, gnt_a_w[k], gnt_b_w[k]);
    end
    if (ack_a_w[k] === 1'b1 || ack_b_w[k] === 1'b1) begin
      total++;
      if (ack_a_w[k] === 1'b1 && ack_b_w[k] === 1'b1) begin
        bad++;
        $display("FAIL ack_mutex_k%0d: both acks high expected one", k);
      end
      port = (ack_b_w[k] === 1'b1);
      if ((k == 0 ? sb0.size() : sb1.size()) == 0) begin
        bad++;
        $display("FAIL unexpected_ack_k%0d: ack on port %0d expected none (t=%0t)", k, port, $time);
      end else begin
        e = (k == 0) ? sb0.pop_front() : sb1.pop_front();
        chk($sformatf("grant_order_k%0d", k), port, e.port);
        chk($sformatf("rdata_k%0d_p%0d", k, port), port ? rd_b_w[k] : rd_a_w[k], e.rd);
      end
    end
  endtask

  always @(negedge clk) if (rst) monitor(0);
  always @(negedge clk) if (rst) monitor(1);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive(k, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      drive(k, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      lock_r[k] = 1'b0;
    end
    for (int i = 0; i < 256; i++) begin
      mem0[i] <= 8'(i);
      mem1[i] <= 8'(i);
    end
    mem0[8'h05] <= 8'h3C;
    mem0[8'h20] <= 8'h11;
    mem0[8'h21] <= 8'h22;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_en0",   en_w[0], 0);
    chk("rst_gnt_a0", gnt_a_w[0], 0);
    chk("rst_ack_b1", ack_b_w[1], 0);
    chk("rst_addr1", maddr_w[1], 8'h00);
    chk("rst_rd_a0", rd_a_w[0], 8'h00);
    rst = 1'b1;

    // A read of 05 with mem_wait=1
    push(0, 1'b0, 8'h3C);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 1'b0, 8'h05, 8'h00);
    @(negedge clk);
    chk("t1_en",      en_w[0], 1);
    chk("t1_addr",    maddr_w[0], 8'h05);
    chk("t1_we",      mwe_w[0], 0);
    chk("t1_gnt_a",   gnt_a_w[0], 1);
    chk("t1_gnt_b",   gnt_b_w[0], 0);
    chk("t1_ack_early", ack_a_w[0], 0);
    @(negedge clk);
    chk("t1_ack",     ack_a_w[0], 1);
    chk("t1_en_off",  en_w[0], 0);
    chk("t1_gnt_done", gnt_a_w[0], 1);
    drive(0, 1'b0, 1'b0, 1'b0, 8'h05, 8'h00);
    @(negedge clk);
    chk("t1_ack_clr", ack_a_w[0], 0);
    chk("t1_gnt_clr", gnt_a_w[0], 0);

    // B write 10 <= A5 with mem_wait=3, then A reads it back
    push(1, 1'b1, 8'h00);
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 1'b1, 8'h10, 8'hA5);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("t2_en_c%0d", c),    en_w[1], 1);
      chk($sformatf("t2_we_c%0d", c),    mwe_w[1], 1);
      chk($sformatf("t2_addr_c%0d", c),  maddr_w[1], 8'h10);
      chk($sformatf("t2_wdata_c%0d", c), mwd_w[1], 8'hA5);
      chk($sformatf("t2_noack_c%0d", c), ack_b_w[1], 0);
    end
    @(negedge clk);
    chk("t2_en_off", en_w[1], 0);
    chk("t2_we_off", mwe_w[1], 0);
    chk("t2_ack_b",  ack_b_w[1], 1);
    chk("t2_gnt_a",  gnt_a_w[1], 0);
    drive(1, 1'b1, 1'b0, 1'b0, 8'h10, 8'hA5);
    push(1, 1'b0, 8'hA5);
    requester(1, 1'b0, 1, 1'b0, 8'h10, 8'h00, 0);

    // addr_a changes mid-access; latched address must hold
    begin
      int  en_cnt;
      bit  got;
      en_cnt = 0;
      got    = 1'b0;
      push(1, 1'b0, 8'h05);
      @(negedge clk);
      drive(1, 1'b0, 1'b1, 1'b0, 8'h05, 8'h00);
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (en_w[1] === 1'b1) begin
          en_cnt++;
          chk($sformatf("t6_addr_c%0d", c), maddr_w[1], 8'h05);
          if (en_cnt == 1) addr_a_r[1] = 8'h07;
        end
        if (ack_a_w[1] === 1'b1) begin
          got = 1'b1;
          break;
        end
      end
      chk("t6_ack_seen", got, 1);
      chk("t6_en_cycles", en_cnt, 3);
      drive(1, 1'b0, 1'b0, 1'b0, 8'h07, 8'h00);
    end

    // Asynchronous reset in the middle of an A read: no ack, outputs drop at once
    repeat (2) @(negedge clk);
    drive(0, 1'b0, 1'b1, 1'b0, 8'h05, 8'h00);
    @(negedge clk);
    chk("t5_en_before", en_w[0], 1);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_en_async",  en_w[0], 0);
    chk("t5_we_async",  mwe_w[0], 0);
    chk("t5_gnt_async", gnt_a_w[0], 0);
    chk("t5_ack_async", ack_a_w[0], 0);
    chk("t5_rd_a0",     rd_a_w[0], 8'h00);
    chk("t5_rd_a1",     rd_a_w[1], 8'h00);
    drive(0, 1'b0, 1'b0, 1'b0, 8'h05, 8'h00);
    repeat (2) @(negedge clk);
    chk("t5_ack_held", ack_a_w[0], 0);
    rst = 1'b1;

    // Tie after reset: A first, then strict alternation
    push(0, 1'b0, 8'h11);
    push(0, 1'b1, 8'h22);
    push(0, 1'b0, 8'h11);
    push(0, 1'b1, 8'h22);
    fork
      requester(0, 1'b0, 2, 1'b0, 8'h20, 8'h00, 0);
      requester(0, 1'b1, 2, 1'b0, 8'h21, 8'h00, 0);
    join

    // lock_b: B,B,B; lock released while B still requests -> A, then B
    lock_r[0] = 1'b1;
    push(0, 1'b1, 8'h22);
    push(0, 1'b1, 8'h22);
    push(0, 1'b1, 8'h22);
    push(0, 1'b0, 8'h11);
    push(0, 1'b1, 8'h22);
    fork
      requester(0, 1'b0, 1, 1'b0, 8'h20, 8'h00, 0);
      requester(0, 1'b1, 4, 1'b0, 8'h21, 8'h00, 3);
    join

    repeat (6) @(negedge clk);
    chk("sb0_drained", sb0.size(), 0);
    chk("sb1_drained", sb1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
